// File: rtl/bl_wl_config_loader.sv
// bl_wl_config_loader: streams DATA_W-bit words into an NUM_BL-bit shadow
// frame, then writes each frame into the tiles by pulsing one wl bit while bl
// is held. Optional abort support is enabled with `define CFG_ABORT_EN.
module bl_wl_config_loader #(
  parameter int NUM_BL   = 160,
  parameter int NUM_WL   = 160,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              cfg_start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
`ifdef CFG_ABORT_EN
  input  logic              cfg_abort,
`endif
  output logic              cfg_ready,
  output logic [0:NUM_BL-1] bl,
  output logic [0:NUM_WL-1] wl,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int WORDS = (NUM_BL + DATA_W - 1) / DATA_W;
  localparam int FW    = (NUM_WL   > 1) ? $clog2(NUM_WL)   : 1;
  localparam int WW    = (WORDS    > 1) ? $clog2(WORDS)    : 1;
  localparam int PW    = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [WW-1:0]     word_q, word_d;
  logic [PW-1:0]     pulse_q, pulse_d;
  logic [0:NUM_BL-1] shadow_q, shadow_d;
  logic [0:NUM_BL-1] bl_q, bl_d;
  logic [0:NUM_WL-1] wl_q, wl_d;
`ifdef CFG_ABORT_EN
  logic              err_q, err_d;
`endif

  // State, counters, shadow frame and registered bus outputs
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      word_q   <= '0;
      pulse_q  <= '0;
      shadow_q <= '0;
      bl_q     <= '0;
      wl_q     <= '0;
`ifdef CFG_ABORT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      word_q   <= word_d;
      pulse_q  <= pulse_d;
      shadow_q <= shadow_d;
      bl_q     <= bl_d;
      wl_q     <= wl_d;
`ifdef CFG_ABORT_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state logic: word capture, pulse timing and frame sequencing
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    word_d   = word_q;
    pulse_d  = pulse_q;
    shadow_d = shadow_q;
`ifdef CFG_ABORT_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          state_d  = S_LOAD;
          frame_d  = '0;
          word_d   = '0;
          shadow_d = '0;
`ifdef CFG_ABORT_EN
          err_d    = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (cfg_valid) begin
          // Bits past NUM_BL in a partial last word are dropped here.
          for (int unsigned w = 0; w < WORDS; w++) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if ((w * DATA_W + i) < NUM_BL && word_q == WW'(w)) begin
                shadow_d[w * DATA_W + i] = cfg_data[i];
              end
            end
          end
          if (word_q == WW'(WORDS - 1)) begin
            state_d = S_WRITE;
            pulse_d = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (pulse_q == PW'(WL_PULSE - 1)) begin
          state_d = S_HOLD;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (frame_q == FW'(NUM_WL - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_LOAD;
          frame_d  = frame_q + 1'b1;
          word_d   = '0;
          shadow_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CFG_ABORT_EN
    if (cfg_abort && (state_q == S_LOAD || state_q == S_WRITE || state_q == S_HOLD)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
`endif
  end

  // Output logic: bus values are computed from the next state so that the
  // registered bl/wl line up exactly with the WRITE/HOLD states
  always_comb begin
    bl_d = '0;
    wl_d = '0;
    if (state_d == S_WRITE || state_d == S_HOLD) begin
      bl_d = shadow_d;
    end
    if (state_d == S_WRITE) begin
      wl_d[frame_d] = 1'b1;
    end
    cfg_ready = (state_q == S_LOAD);
    cfg_busy  = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_HOLD);
    cfg_done  = (state_q == S_DONE);
  end

  assign bl = bl_q;
  assign wl = wl_q;
`ifdef CFG_ABORT_EN
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_bl_wl_config_loader.sv
// Scoreboard bench for bl_wl_config_loader: the driver pushes each expected
// frame when it streams it; a negedge monitor pops and checks on every wl pulse.
module tb_bl_wl_config_loader;
  localparam int NUM_BL   = 160;
  localparam int NUM_WL   = 160;
  localparam int DATA_W   = 8;
  localparam int WL_PULSE = 2;
  localparam int WORDS    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, valid;
  logic [DATA_W-1:0] data;
  logic              ready, busy, done, err;
  logic [0:NUM_BL-1] bl;
  logic [0:NUM_WL-1] wl;
`ifdef CFG_ABORT_EN
  logic              abort;
`endif

  bl_wl_config_loader #(
    .NUM_BL  (NUM_BL),
    .NUM_WL  (NUM_WL),
    .DATA_W  (DATA_W),
    .WL_PULSE(WL_PULSE)
  ) dut (
    .prog_clk    (clk),
    .prog_reset_n(rst_n),
    .cfg_start   (start),
    .cfg_data    (data),
    .cfg_valid   (valid),
`ifdef CFG_ABORT_EN
    .cfg_abort   (abort),
`endif
    .cfg_ready   (ready),
    .bl          (bl),
    .wl          (wl),
    .cfg_busy    (busy),
    .cfg_done    (done),
    .cfg_err     (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_neg_cyc = 0;
  bit skip_len = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                frame;
    logic [0:NUM_BL-1] bits;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [0:NUM_BL-1] frame_bits(input int f);
    logic [0:NUM_BL-1] r;
    logic [7:0] d;
    r = '0;
    for (int w = 0; w < WORDS; w++) begin
      d = 8'(f + w);
      for (int i = 0; i < DATA_W; i++) r[w * DATA_W + i] = d[i];
    end
    return r;
  endfunction

  function automatic int wl_index(input logic [0:NUM_WL-1] v);
    for (int k = 0; k < NUM_WL; k++) if (v[k] === 1'b1) return k;
    return -1;
  endfunction

  // Monitor: bus invariants every cycle, scoreboard compare on each wl pulse
  logic [0:NUM_WL-1] wl_prev = '0;
  logic [0:NUM_BL-1] bl_prev = '0;
  int plen = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ready === 1'b1) begin
      chk("wl_zero_in_load", 256'(wl), '0);
      chk("bl_zero_in_load", 256'(bl), '0);
    end
    if (wl !== '0) begin
      chk("wl_onehot", 256'($onehot(wl)), 256'(1));
      if (wl_prev === '0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wl: wl[%0d] asserted, no frame expected", wl_index(wl));
        end else begin
          cur = q.pop_front();
          chk("wl_index", 256'(wl_index(wl)), 256'(cur.frame));
          chk("bl_frame", 256'(bl), 256'(cur.bits));
        end
        plen = 1;
      end else begin
        plen++;
        chk("wl_stable", 256'(wl), 256'(wl_prev));
        chk("bl_stable_under_wl", 256'(bl), 256'(bl_prev));
      end
    end else if (wl_prev !== '0 && !skip_len) begin
      chk("wl_pulse_len", 256'(plen), 256'(WL_PULSE));
      chk("bl_hold_margin", 256'(bl), 256'(bl_prev));
    end
    wl_prev = wl;
    bl_prev = bl;
  end

  task automatic send_word(input logic [7:0] d, input int gap, input bit pulse_start);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      valid = 1'b0;
      start = 1'b0;
    end
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    start = pulse_start;
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (ready === 1'b1) begin
        last_neg_cyc = cyc;
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %h not accepted, ready=%b required 1", d, ready);
    end
  endtask

  task automatic send_frame(input int f, input bit gaps, input int start_at, input int nwords,
                            output int first_cyc);
    if (nwords == WORDS) q.push_back('{frame: f, bits: frame_bits(f)});
    first_cyc = 0;
    for (int w = 0; w < nwords; w++) begin
      send_word(8'(f + w), gaps ? int'($urandom_range(0, 5)) : 0, (w == start_at));
      if (w == 0) first_cyc = last_neg_cyc;
    end
  endtask

  task automatic wait_done(input bit check_lat, input int first_cyc);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      valid = 1'b0;
      start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: cfg_done=%b required 1", done);
    end else begin
      if (check_lat) chk("done_latency", 256'(cyc - first_cyc), 256'(3680));
      chk("done_busy", 256'(busy), 256'(0));
      chk("done_ready", 256'(ready), 256'(0));
      chk("done_bl", 256'(bl), '0);
      chk("done_wl", 256'(wl), '0);
      chk("done_queue_empty", 256'(q.size()), 256'(0));
    end
  endtask

  task automatic pulse_start_check(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_done_clear"}, 256'(done), 256'(0));
    chk({name, "_busy"}, 256'(busy), 256'(1));
    chk({name, "_ready"}, 256'(ready), 256'(1));
    chk({name, "_err_clear"}, 256'(err), 256'(0));
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int first, dummy;
    bit seen;
    rst_n = 1'b0;
    start = 1'b1;
    valid = 1'b1;
    data  = 8'hA5;
`ifdef CFG_ABORT_EN
    abort = 1'b0;
`endif
    // Reset with start/valid asserted: everything stays quiet
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("rst_ready", 256'(ready), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      chk("rst_bl", 256'(bl), '0);
      chk("rst_wl", 256'(wl), '0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", 256'(ready), 256'(0));
    chk("idle_busy", 256'(busy), 256'(0));

    // Full streaming load with an ignored start pulse inside frame 10
    pulse_start_check("start0");
    first = 0;
    for (int f = 0; f < NUM_WL; f++) begin
      send_frame(f, 1'b0, (f == 10) ? 5 : -1, WORDS, dummy);
      if (f == 0) first = dummy;
    end
    wait_done(1'b1, first);
    chk("stream_err", 256'(err), 256'(0));

    // Restart from DONE and reload under random backpressure
    pulse_start_check("restart_bp");
    for (int f = 0; f < NUM_WL; f++) send_frame(f, 1'b1, -1, WORDS, dummy);
    wait_done(1'b0, 0);

    // Reset while wl[5] is high, then reprogram from wl[0]
    pulse_start_check("restart_rst");
    for (int f = 0; f < 5; f++) send_frame(f, 1'b0, -1, WORDS, dummy);
    skip_len = 1'b1;
    send_frame(5, 1'b0, -1, WORDS, dummy);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      valid = 1'b0;
      if (wl[5] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wl5_seen", 256'(seen), 256'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_wl", 256'(wl), '0);
    chk("midrst_bl", 256'(bl), '0);
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_ready", 256'(ready), 256'(0));
    @(negedge clk);
    skip_len = 1'b0;
    chk("midrst_idle_ready", 256'(ready), 256'(0));
    chk("midrst_queue_empty", 256'(q.size()), 256'(0));
    pulse_start_check("after_rst");
    send_frame(0, 1'b0, -1, WORDS, dummy);
    repeat (4) @(negedge clk);
    valid = 1'b0;
    chk("reprog_frame0_seen", 256'(q.size()), 256'(0));

`ifdef CFG_ABORT_EN
    // Abort during word 7 of frame 3: no wl for frame 3, sticky error
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start_check("abort_run");
    for (int f = 0; f < 3; f++) send_frame(f, 1'b0, -1, WORDS, dummy);
    send_frame(3, 1'b0, -1, 7, dummy);
    @(negedge clk);
    valid = 1'b1;
    data  = 8'(3 + 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    valid = 1'b0;
    chk("abort_err", 256'(err), 256'(1));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_ready", 256'(ready), 256'(0));
    chk("abort_wl", 256'(wl), '0);
    chk("abort_bl", 256'(bl), '0);
    repeat (30) @(negedge clk);
    chk("abort_err_sticky", 256'(err), 256'(1));
    chk("abort_no_frame3", 256'(q.size()), 256'(0));
    pulse_start_check("after_abort");
`else
    chk("err_tied_low", 256'(err), 256'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
